// File: rtl/dsi_init_sequencer.sv
// Bring-up sequencer for the DSI core CSR port: plays a command ROM as Wishbone
// writes, polled reads and delays, and hands the port to the CPU when idle.
module dsi_init_sequencer #(
    parameter int g_rom_addr_width = 8,
    parameter int g_delay_unit     = 1000,
    parameter int g_poll_limit     = 255,
    parameter int g_ack_timeout    = 64
) (
    input  logic                        clk_sys_i,
    input  logic                        rst_n_i,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [g_rom_addr_width-1:0] err_addr_o,
    output logic [g_rom_addr_width-1:0] cmd_addr_o,
    input  logic [15:0]                 cmd_data_i,
    input  logic [3:0]                  host_adr_i,
    input  logic [7:0]                  host_dat_i,
    input  logic                        host_cyc_i,
    input  logic                        host_stb_i,
    input  logic                        host_we_i,
    output logic [7:0]                  host_dat_o,
    output logic                        host_ack_o,
    output logic                        host_stall_o,
    output logic [3:0]                  wb_adr_o,
    output logic [7:0]                  wb_dat_o,
    output logic                        wb_cyc_o,
    output logic                        wb_stb_o,
    output logic                        wb_we_o,
    input  logic [7:0]                  wb_dat_i,
    input  logic                        wb_ack_i,
    input  logic                        wb_stall_i
);

    localparam int AW     = g_rom_addr_width;
    localparam int DLY_W  = $clog2(255 * g_delay_unit + 1);
    localparam int TMO_W  = $clog2(g_ack_timeout + 1);
    localparam int PCNT_W = $clog2(g_poll_limit + 1);

    localparam logic [DLY_W-1:0]  DLY_UNIT  = DLY_W'(g_delay_unit);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(g_ack_timeout - 1);
    localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(g_poll_limit - 1);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_WB_REQ   = 4'd3;
    localparam logic [3:0] ST_WB_ACK   = 4'd4;
    localparam logic [3:0] ST_POLL_CHK = 4'd5;
    localparam logic [3:0] ST_DELAY    = 4'd6;
    localparam logic [3:0] ST_DONE     = 4'd7;
    localparam logic [3:0] ST_ERR      = 4'd8;

    localparam logic [3:0] OP_END   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_POLL  = 4'h2;
    localparam logic [3:0] OP_DELAY = 4'h3;

    logic [3:0]        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [AW-1:0]     err_addr_q, err_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              start_pend_q, start_pend_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [3:0]        adr_q, adr_d;
    logic [7:0]        dat_q, dat_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [PCNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              advance;

    always_comb begin
        // NOTE: every *_d starts from its *_q so no path through the case leaves a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        err_addr_d   = err_addr_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        start_pend_d = start_pend_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        rdata_d      = rdata_q;
        poll_cnt_d   = poll_cnt_q;
        tmo_d        = tmo_q;
        dly_d        = dly_q;
        advance      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A start seen while the CPU owns the bus is remembered until it lets go.
                if ((start_i || start_pend_q) && !host_cyc_i) begin
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    start_pend_d = 1'b0;
                    pc_d         = '0;
                    state_d      = ST_FETCH;
                end else if (start_i) begin
                    start_pend_d = 1'b1;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                adr_d      = cmd_data_i[11:8];
                dat_d      = cmd_data_i[7:0];
                poll_cnt_d = '0;
                case (cmd_data_i[15:12])
                    OP_WRITE, OP_POLL: begin
                        we_d    = (cmd_data_i[15:12] == OP_WRITE);
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = ST_WB_REQ;
                    end
                    OP_DELAY: begin
                        dly_d   = DLY_W'(cmd_data_i[7:0]) * DLY_UNIT;
                        state_d = ST_DELAY;
                    end
                    OP_END:  state_d = ST_DONE;
                    default: state_d = ST_ERR;
                endcase
            end
            ST_WB_REQ: begin
                if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = ST_WB_ACK;
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WB_ACK: begin
                if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    if (we_q) begin
                        advance = 1'b1;
                    end else begin
                        rdata_d = wb_dat_i;
                        state_d = ST_POLL_CHK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_POLL_CHK: begin
                if ((rdata_q & dat_q) != 8'h00) begin
                    advance = 1'b1;
                end else if (poll_cnt_q == POLL_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    poll_cnt_d = poll_cnt_q + PCNT_W'(1);
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    tmo_d      = '0;
                    state_d    = ST_WB_REQ;
                end
            end
            ST_DELAY: begin
                // Leaving on the cycle the counter shows 1 gives exactly count*unit cycles.
                if (dly_q <= DLY_W'(1)) begin
                    advance = 1'b1;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                error_d    = 1'b1;
                busy_d     = 1'b0;
                err_addr_d = pc_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Running off the end of the ROM without an END keeps pc on the last entry.
        if (advance) begin
            if (&pc_q) begin
                state_d = ST_ERR;
            end else begin
                pc_d    = pc_q + AW'(1);
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            err_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            start_pend_q <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            rdata_q      <= '0;
            poll_cnt_q   <= '0;
            tmo_q        <= '0;
            dly_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            err_addr_q   <= err_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            start_pend_q <= start_pend_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            rdata_q      <= rdata_d;
            poll_cnt_q   <= poll_cnt_d;
            tmo_q        <= tmo_d;
            dly_q        <= dly_d;
        end
    end

    // busy_q doubles as the grant: it only changes while the sequencer's cyc is low.
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_addr_o = err_addr_q;
    assign cmd_addr_o = pc_q;

    assign wb_cyc_o = busy_q ? cyc_q : host_cyc_i;
    assign wb_stb_o = busy_q ? stb_q : host_stb_i;
    assign wb_we_o  = busy_q ? we_q  : host_we_i;
    assign wb_adr_o = busy_q ? adr_q : host_adr_i;
    assign wb_dat_o = busy_q ? dat_q : host_dat_i;

    assign host_dat_o   = busy_q ? 8'h00 : wb_dat_i;
    assign host_ack_o   = busy_q ? 1'b0  : wb_ack_i;
    assign host_stall_o = busy_q ? 1'b1  : wb_stall_i;

endmodule

// File: tb/tb_dsi_init_sequencer.sv
// Directed bench for dsi_init_sequencer: ROM model, one-wait-state slave with
// write/read logs, and hand-computed expectations for each scenario.
module tb_dsi_init_sequencer;

    logic        clk_sys_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic        busy_o, done_o, error_o;
    logic [7:0]  err_addr_o, cmd_addr_o;
    logic [15:0] cmd_data_i = 16'h0000;
    logic [3:0]  host_adr_i;
    logic [7:0]  host_dat_i;
    logic        host_cyc_i, host_stb_i, host_we_i;
    logic [7:0]  host_dat_o;
    logic        host_ack_o, host_stall_o;
    logic [3:0]  wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]  wb_dat_i;
    logic        wb_ack_i, wb_stall_i;

    int n_vec = 0;
    int n_err = 0;

    dsi_init_sequencer #(
        .g_rom_addr_width(8),
        .g_delay_unit    (10),
        .g_poll_limit    (4),
        .g_ack_timeout   (64)
    ) dut (
        .clk_sys_i   (clk_sys_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .err_addr_o  (err_addr_o),
        .cmd_addr_o  (cmd_addr_o),
        .cmd_data_i  (cmd_data_i),
        .host_adr_i  (host_adr_i),
        .host_dat_i  (host_dat_i),
        .host_cyc_i  (host_cyc_i),
        .host_stb_i  (host_stb_i),
        .host_we_i   (host_we_i),
        .host_dat_o  (host_dat_o),
        .host_ack_o  (host_ack_o),
        .host_stall_o(host_stall_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_stall_i  (wb_stall_i)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    // Synchronous command ROM
    logic [15:0] rom [0:255];
    always @(posedge clk_sys_i) cmd_data_i <= rom[cmd_addr_o];

    // Slave: acks the cycle after an accepted strobe, logs writes and reads
    logic       stall_hold = 1'b0;
    logic       clr_log = 1'b0;
    logic       ack_q = 1'b0;
    logic [7:0] rdat_q = 8'h00;
    logic [7:0] rd_vals [0:7];
    logic [3:0] wr_adr [0:15];
    logic [7:0] wr_dat [0:15];
    int         wr_cyc [0:15];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         cyc_cnt = 0;

    assign wb_stall_i = stall_hold;
    assign wb_ack_i   = ack_q;
    assign wb_dat_i   = rdat_q;

    always @(posedge clk_sys_i) begin
        cyc_cnt <= cyc_cnt + 1;
        ack_q   <= wb_cyc_o && wb_stb_o && !wb_stall_i;
        if (clr_log) begin
            wr_cnt <= 0;
            rd_cnt <= 0;
        end else if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
            if (wb_we_o) begin
                if (wr_cnt < 16) begin
                    wr_adr[wr_cnt] <= wb_adr_o;
                    wr_dat[wr_cnt] <= wb_dat_o;
                    wr_cyc[wr_cnt] <= cyc_cnt;
                end
                wr_cnt <= wr_cnt + 1;
            end else begin
                rdat_q <= (rd_cnt < 8) ? rd_vals[rd_cnt] : 8'h00;
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys_i);
        #1;
    endtask

    task automatic rom_fill(input logic [15:0] word);
        for (int i = 0; i < 256; i++) rom[i] = word;
        for (int i = 0; i < 8; i++) rd_vals[i] = 8'h00;
    endtask

    task automatic clear_log();
        clr_log = 1'b1;
        tick();
        clr_log = 1'b0;
    endtask

    // Pulse start, then wait (bounded) for done or error
    task automatic run_seq(input int max_cyc);
        int n;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!(done_o || error_o) && n < max_cyc) begin
            tick();
            n++;
        end
        check("seq_finished", 32'(done_o | error_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gap;
        int n;
        logic ack_seen, stall_low;

        rst_n_i    = 1'b0;
        start_i    = 1'b0;
        host_adr_i = 4'h0;
        host_dat_i = 8'h00;
        host_cyc_i = 1'b0;
        host_stb_i = 1'b0;
        host_we_i  = 1'b0;
        rom_fill(16'h0000);
        repeat (2) tick();

        // Reset state
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_err_addr", 32'(err_addr_o), 32'd0);
        check("rst_cmd_addr", 32'(cmd_addr_o), 32'd0);
        check("rst_wb_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_wb_stb", 32'(wb_stb_o), 32'd0);
        stall_hold = 1'b1;
        #1;
        check("rst_stall_passthru", 32'(host_stall_o), 32'd1);
        stall_hold = 1'b0;
        rst_n_i = 1'b1;
        tick();

        // Two writes then END, with start latency and completion timing
        rom_fill(16'h0000);
        rom[0] = 16'h1040;
        rom[1] = 16'h1110;
        clear_log();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_busy", 32'(busy_o), 32'd1);
        check("start_cmd_addr", 32'(cmd_addr_o), 32'd0);
        repeat (2) tick();
        check("e2_stb", 32'(wb_stb_o), 32'd1);
        check("e2_we", 32'(wb_we_o), 32'd1);
        check("e2_adr", 32'(wb_adr_o), 32'h0);
        check("e2_dat", 32'(wb_dat_o), 32'h40);
        repeat (3) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        check("e10_done_low", 32'(done_o), 32'd0);
        check("e10_busy", 32'(busy_o), 32'd1);
        tick();
        check("e11_done", 32'(done_o), 32'd1);
        check("e11_busy", 32'(busy_o), 32'd0);
        repeat (3) tick();
        check("no_requeue", 32'(busy_o), 32'd0);
        check("wr_count", 32'(wr_cnt), 32'd2);
        check("wr0_adr", 32'(wr_adr[0]), 32'h0);
        check("wr0_dat", 32'(wr_dat[0]), 32'h40);
        check("wr1_adr", 32'(wr_adr[1]), 32'h1);
        check("wr1_dat", 32'(wr_dat[1]), 32'h10);

        // POLL that hits on the third read
        rom_fill(16'h0000);
        rom[0] = 16'h2002;
        rd_vals[2] = 8'h02;
        clear_log();
        run_seq(200);
        check("poll_done", 32'(done_o), 32'd1);
        check("poll_no_err", 32'(error_o), 32'd0);
        check("poll_reads", 32'(rd_cnt), 32'd3);

        // POLL that never hits: limit of 4 reads, error at the POLL index
        rom_fill(16'h0000);
        rom[0] = 16'h1005;
        rom[1] = 16'h2001;
        clear_log();
        run_seq(300);
        check("plim_error", 32'(error_o), 32'd1);
        check("plim_done_cleared", 32'(done_o), 32'd0);
        check("plim_reads", 32'(rd_cnt), 32'd4);
        check("plim_err_addr", 32'(err_addr_o), 32'd1);

        // DELAY 3 x 10: write accepts 4 + 2 + 30 = 36 cycles apart (+-1 allowed)
        rom_fill(16'h0000);
        rom[0] = 16'h1040;
        rom[1] = 16'h3003;
        rom[2] = 16'h1110;
        clear_log();
        run_seq(200);
        check("dly_done", 32'(done_o), 32'd1);
        check("dly_error_cleared", 32'(error_o), 32'd0);
        check("dly_wr_count", 32'(wr_cnt), 32'd2);
        gap = wr_cyc[1] - wr_cyc[0];
        check("dly_gap", (gap >= 35 && gap <= 37) ? 32'd36 : 32'(gap), 32'd36);

        // Unknown opcode
        rom_fill(16'h0000);
        rom[0] = 16'h1001;
        rom[1] = 16'h7000;
        clear_log();
        run_seq(100);
        check("badop_error", 32'(error_o), 32'd1);
        check("badop_err_addr", 32'(err_addr_o), 32'd1);
        check("badop_wr_count", 32'(wr_cnt), 32'd1);

        // Slave stalls forever: 64 cycles in WB_REQ, then cyc/stb dropped
        rom_fill(16'h0000);
        rom[0] = 16'h1040;
        stall_hold = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (65) tick();
        check("tmo_cyc_before", 32'(wb_cyc_o), 32'd1);
        tick();
        check("tmo_cyc_dropped", 32'(wb_cyc_o), 32'd0);
        check("tmo_stb_dropped", 32'(wb_stb_o), 32'd0);
        tick();
        check("tmo_error", 32'(error_o), 32'd1);
        check("tmo_err_addr", 32'(err_addr_o), 32'd0);
        check("tmo_busy", 32'(busy_o), 32'd0);

        // Asynchronous reset mid-transaction, no resume afterwards
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        check("arst_cyc_before", 32'(wb_cyc_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        check("arst_cyc", 32'(wb_cyc_o), 32'd0);
        check("arst_stb", 32'(wb_stb_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        #1;
        rst_n_i = 1'b1;
        stall_hold = 1'b0;
        repeat (3) tick();
        check("arst_no_resume", 32'(busy_o), 32'd0);

        // ROM with no END: pc wrap is an error at the last entry
        rom_fill(16'h3000);
        run_seq(1000);
        check("wrap_error", 32'(error_o), 32'd1);
        check("wrap_err_addr", 32'(err_addr_o), 32'hff);

        // Arbitration: start deferred by CPU cyc, CPU stalled while busy
        rom_fill(16'h0000);
        rom[0] = 16'h1040;
        clear_log();
        host_cyc_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        check("arb_deferred", 32'(busy_o), 32'd0);
        host_cyc_i = 1'b0;
        tick();
        check("arb_started", 32'(busy_o), 32'd1);
        host_cyc_i = 1'b1;
        host_stb_i = 1'b1;
        host_we_i  = 1'b1;
        host_adr_i = 4'h5;
        host_dat_i = 8'h55;
        ack_seen  = 1'b0;
        stall_low = 1'b0;
        n = 0;
        #1;
        while (busy_o && n < 20) begin
            if (host_ack_o) ack_seen = 1'b1;
            if (!host_stall_o) stall_low = 1'b1;
            tick();
            n++;
        end
        check("arb_seq_done", 32'(done_o), 32'd1);
        check("arb_cpu_no_ack", 32'(ack_seen), 32'd0);
        check("arb_cpu_stalled", 32'(stall_low), 32'd0);
        tick();
        check("arb_cpu_ack", 32'(host_ack_o), 32'd1);
        host_cyc_i = 1'b0;
        host_stb_i = 1'b0;
        host_we_i  = 1'b0;
        tick();
        check("arb_wr_count", 32'(wr_cnt), 32'd2);
        check("arb_seq_wr_dat", 32'(wr_dat[0]), 32'h40);
        check("arb_cpu_wr_adr", 32'(wr_adr[1]), 32'h5);
        check("arb_cpu_wr_dat", 32'(wr_dat[1]), 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dsi_init_sequencer.md
# dsi_init_sequencer

Autonomous bring-up sequencer and host-bus arbiter for the DSI core's CSR port. It fetches 16-bit commands from a synchronous command ROM and issues them as Wishbone-pipelined writes, polled reads and timed delays to the core: reset pin, tick divider, LP_TX bytes and enables. When the sequencer is idle, the port is granted to the CPU master as a transparent pass-through. It sits in the clk_sys_i domain between the CPU interconnect and the DSI core's wb_* slave.

## Interface
- g_rom_addr_width, 8: command ROM address width; 2^N entries.
- g_delay_unit, 1000: clk_sys_i cycles per DELAY count.
- g_poll_limit, 255: maximum reads per POLL before error.
- g_ack_timeout, 64: clk_sys_i cycles waiting for stall-low or ack before error.
- clk_sys_i  in  1  system clock; all logic on its rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  level-sampled start request; honoured only in IDLE.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sticky, set on END; cleared by the next accepted start.
- error_o  out  1  sticky, set on bad opcode, timeout or poll limit; cleared by the next accepted start.
- err_addr_o  out  g_rom_addr_width  ROM address of the failing command.
- cmd_addr_o  out  g_rom_addr_width  ROM address.
- cmd_data_i  in  16  ROM data, valid one cycle after cmd_addr_o.
- host_adr_i[3:0], host_dat_i[7:0], host_cyc_i, host_stb_i, host_we_i  in  CPU Wishbone slave inputs.
- host_dat_o[7:0], host_ack_o, host_stall_o  out  CPU Wishbone slave outputs.
- wb_adr_o[3:0], wb_dat_o[7:0], wb_cyc_o, wb_stb_o, wb_we_o  out  master to DSI core.
- wb_dat_i[7:0], wb_ack_i, wb_stall_i  in  from DSI core.

## Operation
- Command word: [15:12] opcode, [11:8] register address, [7:0] data or mask or count.
  - 0x0 END: finishes the sequence.
  - 0x1 WRITE: writes data to the register address.
  - 0x2 POLL: reads the register address until (rdata & mask) != 0.
  - 0x3 DELAY: waits count × g_delay_unit cycles; count 0 takes one cycle.
  - Any other opcode is an error.
- States: IDLE, FETCH, DECODE, WB_REQ, WB_ACK, POLL_CHK, DELAY, DONE, ERR.
- IDLE: if start_i=1 and host_cyc_i=0, take the grant, clear done/error, set pc=0, go to FETCH. If host_cyc_i=1, the start is deferred until the CPU drops cyc.
- FETCH: cmd_addr_o=pc; go to DECODE.
- DECODE: latch cmd_data_i.
  - WRITE or POLL go to WB_REQ.
  - DELAY loads the down-counter and goes to DELAY.
  - END goes to DONE.
  - A bad opcode goes to ERR.
- WB_REQ:
  - Drive cyc=stb=1; we=1 for WRITE, 0 for POLL.
  - When wb_stall_i=0, drop stb and go to WB_ACK.
- WB_ACK:
  - Hold cyc=1 until wb_ack_i.
  - On ack, drop cyc. WRITE does pc++ and goes to FETCH. POLL captures wb_dat_i and goes to POLL_CHK.
- POLL_CHK:
  - On a mask hit: pc++ and go to FETCH.
  - Otherwise increment the poll counter; if it reaches g_poll_limit, go to ERR, else go to WB_REQ.
- DELAY: count to zero, then pc++ and go to FETCH.
- Timeout: the g_ack_timeout counter restarts on entry to WB_REQ and WB_ACK. Expiry goes to ERR with cyc and stb dropped in the same cycle.
- pc wrap: pc wrapping past the last entry (2^N−1 → 0) without an END is an error; err_addr_o = 2^N−1.
- DONE and ERR: set the sticky flag, busy_o=0, return to IDLE, release the grant.
- Arbitration:
  - While busy_o=1: host_stall_o=1, host_ack_o=0, host_dat_o=0.
  - While idle: host_* is passed to and from wb_* combinationally.
  - The grant never changes while the current owner has cyc high.

## Timing
- Reset values:
  - busy_o, done_o, error_o, err_addr_o, cmd_addr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o are all 0.
  - The grant belongs to the CPU, so host_* outputs follow the pass-through.
- Start latency: start_i sampled at edge E gives busy_o=1 and cmd_addr_o=0 after E; DECODE after E+1; wb_stb_o=1 after E+2.
- One-wait-state slave: a WRITE with stall=0 and ack in the following cycle takes 4 cycles, fetch to next fetch.
- Reset mid-sequence: an asynchronous rst_n_i drops cyc and stb immediately; no partial transaction is resumed.
- A start_i during busy is ignored; there is no queued restart.

## Test plan
- ROM {0x1040, 0x1110, 0x0000}, slave always acks next cycle:
  - wb writes adr0=0x40, then adr1=0x10.
  - done_o=1, busy_o=0 eleven cycles after start.
- POLL 0x2002, slave returns 0x00, 0x00, 0x02 → exactly 3 reads, then advance; done_o=1.
- POLL with slave always 0x00, g_poll_limit=4 → 4 reads, error_o=1, err_addr_o=index of the POLL.
- DELAY 0x3003 with g_delay_unit=10 → 30 idle cycles between the neighbouring wb transactions (±1).
- Slave holds wb_stall_i=1 → after 64 cycles error_o=1 and wb_cyc_o=0.
- Arbitration: CPU cyc held when start_i pulses → the sequencer starts only after host_cyc_i falls. A CPU stb during busy sees host_stall_o=1 and no ack; it completes after done.
